// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request/response bus between execute stage and data memory
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        hold;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, resp_valid, resp_rdata, resp_err, hold
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, resp_valid, resp_rdata, resp_err, hold
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with wait states, lane-strobed stores and extended loads (optional MISALIGN_TRAP_EN)
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          a_we, a_uns;
    logic [31:0]   a_addr, a_wdata;
    logic [1:0]    a_size;
    logic [AW-1:0] idx;
    logic          oor, misalign, acc_err, wr_en;
    logic [31:0]   word, load_v, wrep, new_word;
    logic [7:0]    b_sel;
    logic [15:0]   h_sel;
    logic [3:0]    be;

    // With zero wait states the access happens on the accept edge, so take fields straight from the bus
    always_comb begin
        a_we     = state_q == IDLE ? bus.req_we       : we_q;
        a_addr   = state_q == IDLE ? bus.req_addr     : addr_q;
        a_wdata  = state_q == IDLE ? bus.req_wdata    : wdata_q;
        a_size   = state_q == IDLE ? bus.req_size     : size_q;
        a_uns    = state_q == IDLE ? bus.req_unsigned : uns_q;
        idx      = a_addr[AW+1:2];
        oor      = a_addr[31:AW+2] != '0;
`ifdef MISALIGN_TRAP_EN
        misalign = (a_size == 2'b01 && a_addr[0]) || (a_size == 2'b10 && a_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        acc_err  = oor || a_size == 2'b11 || misalign;
        word     = mem[idx];
        b_sel    = word[{a_addr[1:0], 3'b000} +: 8];
        h_sel    = word[{a_addr[1], 4'b0000} +: 16];
        load_v   = a_size == 2'b00 ? {{24{b_sel[7] & ~a_uns}}, b_sel} :
                   a_size == 2'b01 ? {{16{h_sel[15] & ~a_uns}}, h_sel} : word;
        be       = a_size == 2'b00 ? 4'b0001 << a_addr[1:0] :
                   a_size == 2'b01 ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wrep     = a_size == 2'b00 ? {4{a_wdata[7:0]}} :
                   a_size == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
        new_word = word;
        for (int i = 0; i < 4; i++)
            new_word[8*i +: 8] = be[i] ? wrep[8*i +: 8] : word[8*i +: 8];
    end

    // Next-state logic: accept in IDLE, count down wait states, one-cycle response
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = 1'b0;
        if (state_q == IDLE && bus.req_valid) begin
            we_d    = bus.req_we;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            size_d  = bus.req_size;
            uns_d   = bus.req_unsigned;
            state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
        end else if (state_q == WAIT) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd0 ? RESP : WAIT;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
        if (state_d == RESP) begin
            valid_d = 1'b1;
            rdata_d = (acc_err || a_we) ? 32'd0 : load_v;
            err_d   = acc_err;
        end
        wr_en = state_d == RESP && a_we && !acc_err;
    end

    // FSM and response registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Store commits on the edge entering RESP, never while reset is asserted
    always_ff @(posedge clk) begin
        if (rst && wr_en)
            mem[idx] <= new_word;
    end

    assign bus.req_ready  = state_q == IDLE;
    assign bus.hold       = (state_q == IDLE && bus.req_valid) || state_q == WAIT;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the CPU's load/store path; the memory side of the request/response interface that the execute stage drives.
- Accepts one request at a time and inserts a programmable number of wait states.
- Performs byte/half/word writes with lane strobing and returns sign- or zero-extended load data.
- Drives a stall line back to the pipeline so earlier stages freeze while an access is in flight.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >= 4)
WAIT_CYCLES, 2, wait states between acceptance and response (0..15)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  access error, valid with resp_valid
hold  output  1  pipeline stall request

Behaviour:
- Reset:
  - Applied when rst==0 at a clk edge; reset is synchronous and active-low.
  - Reset state: IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0.
  - The memory array is not reset.
- FSM states IDLE, WAIT, RESP; req_ready = (state==IDLE).
- Accept:
  - Occurs when req_valid && req_ready; latch we, addr, wdata, size, unsigned.
  - Next state is WAIT with counter = WAIT_CYCLES-1, or RESP directly if WAIT_CYCLES==0.
- WAIT:
  - Counter decrements each cycle; at counter==0 the next state is RESP.
  - Time in WAIT is exactly WAIT_CYCLES cycles.
- Memory access:
  - Array write and read sample happen on the edge that enters RESP.
  - A later request sees earlier stores; same-word read-after-write returns the new data.
- RESP:
  - resp_valid=1 for exactly one cycle; there is no backpressure.
  - Next state is always IDLE.
  - resp_rdata and resp_err hold their value until the next response.
- Latency and throughput:
  - Acceptance edge to resp_valid high is WAIT_CYCLES+1 cycles.
  - Minimum spacing between acceptances is WAIT_CYCLES+2 cycles.
- hold = (state==IDLE && req_valid) || state==WAIT; hold is 0 in RESP.
- Addressing:
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2].
  - If req_addr[31:2] >= DEPTH_WORDS: resp_err=1, no write, rdata 0.
- Stores:
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0}/{addr[1],1}.
  - Word: all four lanes are written.
  - Unwritten lanes are preserved.
  - resp_rdata = 0.
- Loads:
  - Extract the selected byte or half, then extend per req_unsigned.
  - Word loads ignore req_unsigned.
- req_size==11: resp_err=1, no write, rdata 0.
- Simultaneous events:
  - A request arriving while not IDLE is ignored; the requester holds req_valid.
  - A new req_valid in the RESP cycle is accepted on the following IDLE cycle.
- Reset mid-operation: aborts the access. An uncommitted store (not yet in RESP) never reaches the array, and no response is produced.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Half access with addr[0]!=0, or word access with addr[1:0]!=0, gives resp_err=1, no write, rdata 0.
  - Error timing is unchanged (still WAIT_CYCLES+1).
- Undefined:
  - Misaligned low bits are silently masked: half ignores addr[0], word ignores addr[1:0].
  - resp_err is never set for alignment.

Test Plan:
- Reset and idle: rst=0 for 2 cycles, release -> req_ready=1, resp_valid=0, hold=0; resp_rdata=0.
- Word store then load, WAIT_CYCLES=2:
  - Stimulus: store 0xDEADBEEF @0x10, then load word @0x10.
  - Response: resp_valid 3 cycles after each accept; load rdata=0xDEADBEEF; hold high from request through WAIT.
- Byte/half lanes:
  - Stimulus: word 0x11223344 @0x20, then store byte 0xAA @0x22.
  - Response: word load=0x11AA3344; signed byte load @0x22=0xFFFFFFAA; unsigned=0x000000AA; signed half load @0x22=0x000011AA.
- Errors:
  - Stimulus: load @ DEPTH_WORDS*4, and a size=11 request.
  - Response: resp_err=1, rdata 0, array unchanged.
  - MISALIGN_TRAP_EN: word load @0x11 gives err=1. Without the macro it returns the word @0x10.
- WAIT_CYCLES=0 back-to-back:
  - Stimulus: req_valid held high for 4 loads.
  - Response: accepts every 2 cycles; resp_valid on alternate cycles.
- Reset mid-store:
  - Stimulus: store 0x55 @0x30 accepted, rst=0 during WAIT.
  - Response: no resp_valid; a later load @0x30 returns the prior value.
